bextdep_arbiter: RTL and testbench
==================================

BEXTDEP_ARBITER -- requirements
Module: bextdep_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2: clock edges from operand presentation to valid rd on the shared smartbextdep unit.
REQ-002 SHALL have parameter BUF_DEPTH, default 4: result FIFO entries per requester; legal range 2..8.
REQ-003 SHALL have input clock, 1 bit; the single clock, all state rising-edge.
REQ-004 SHALL have input reset, 1 bit; asynchronous, active-high.
REQ-005 SHALL have, for N in {0,1}, input reqN_valid, 1 bit; requester N presents an operation.
REQ-006 SHALL have, for N in {0,1}, output reqN_ready, 1 bit; operation N accepted this cycle.
REQ-007 SHALL have, for N in {0,1}, input reqN_bdep, 1 bit; 1 = bdep, 0 = bext.
REQ-008 SHALL have, for N in {0,1}, inputs reqN_rs1 and reqN_rs2, 32 bits each; operands.
REQ-009 SHALL have, for N in {0,1}, output respN_valid, 1 bit; result available.
REQ-010 SHALL have, for N in {0,1}, input respN_ready, 1 bit; requester N consumes the result.
REQ-011 SHALL have, for N in {0,1}, output respN_rd, 32 bits; result data.

Function
REQ-012 SHALL transfer an operation when reqN_valid and reqN_ready are both high on a rising edge; requesters hold valid and payload stable until ready.
REQ-013 SHALL assert at most one reqN_ready per cycle and SHALL issue at most one operation per cycle to the shared unit.
REQ-014 SHALL keep a credit count per requester = in-flight ops + FIFO occupancy; requester N is eligible only when its credit count < BUF_DEPTH.
REQ-015 SHALL arbitrate round-robin: if both are eligible and valid, grant the requester not granted last; if only one is eligible and valid, grant it; an ineligible requester is skipped without blocking the other.
REQ-016 SHALL carry a 1-bit owner tag plus valid bit through a LAT-deep shift register aligned with the unit pipeline.
REQ-017 SHALL write rd into the owner's FIFO on the edge where the tagged entry exits the pipeline; respN_valid rises one cycle later (issue to respN_valid = LAT+1 cycles).
REQ-018 SHALL return results to each requester in issue order.
REQ-019 SHALL allow simultaneous FIFO write and respN_ready pop in one cycle without loss; the credit count is unchanged in a cycle with both an issue and a pop for the same requester.
REQ-020 SHALL never overflow a FIFO (guaranteed by REQ-014); FIFO pointers wrap modulo BUF_DEPTH.
REQ-021 SHALL sustain one issue per cycle for a single requester with respN_ready held high, given BUF_DEPTH >= LAT+2.

Reset
REQ-022 SHALL, while reset is high, force reqN_ready=0, respN_valid=0, respN_rd=0, credits=0, FIFOs empty, pipeline tag valids cleared, round-robin pointer favouring requester 0.
REQ-023 SHALL discard in-flight operations on reset assertion mid-operation; no result for them emerges after release.

Configuration
REQ-024 SHALL, with BEXTDEP_ARB_PERF_EN defined, add outputs perf_issue0, perf_issue1 (32-bit per-requester issue counts) and perf_conflict (32-bit count of cycles with both reqN_valid high), reset to 0, wrapping at 2^32.
REQ-025 SHALL, without BEXTDEP_ARB_PERF_EN, omit those ports and counters entirely; function is otherwise identical.

Structure
REQ-026 SHALL place LAT default, BUF_DEPTH default, requester count and the owner-tag width constant in a shared package bextdep_arb_pkg.
REQ-027 SHALL instantiate exactly one smartbextdep as the shared datapath; the per-requester FIFO SHALL be one sub-module, bextdep_arb_fifo, instantiated twice.

Verification
REQ-028 Req0 bext rs1=0x12345678 rs2=0x0000FF00, req1 idle -> req0_ready same cycle, resp0_rd=0x00000056 at LAT+1 cycles.
REQ-029 Req1 bdep rs1=0x000000A5 rs2=0x0F0F0000 alone -> resp1_rd=0x0A050000.
REQ-030 Both valid every cycle for 20 cycles, both resp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset, 10 results each, in order.
REQ-031 Req0 streaming, resp0_ready=0 -> exactly BUF_DEPTH (4) issues accepted, then req0_ready=0 while req1 continues to be granted every cycle.
REQ-032 Reset asserted 1 cycle after issue of an op -> all outputs 0 immediately; no respN_valid after release until a new issue.
REQ-033 With BEXTDEP_ARB_PERF_EN, REQ-030 stimulus -> perf_issue0=10, perf_issue1=10, perf_conflict=20.

Source files
------------

// File: rtl/bextdep_arb_pkg.sv
// Shared constants and types for the two-requester bext/bdep arbiter.
package bextdep_arb_pkg;

  localparam int LAT_DEFAULT       = 2;
  localparam int BUF_DEPTH_DEFAULT = 4;
  localparam int NUM_REQ           = 2;
  localparam int TAG_W             = 1;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] owner;
  } tag_t;

endpackage

// File: rtl/bextdep_arb_fifo.sv
// Generic result FIFO; push visible at pop_dat one cycle later, pop_dat reads 0 when empty.
// No internal backpressure: the caller's credit scheme guarantees it never overflows.
module bextdep_arb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= push_dat;
  end

  assign empty   = (count == '0);
  assign pop_dat = empty ? '0 : mem[rptr];

endmodule

// File: rtl/smartbextdep.sv
// Pipelined bit extract / deposit unit, rd valid LAT edges after operands.
// No backpressure: accepts new operands every cycle.
module smartbextdep #(
  parameter int LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bdep,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd
);

  function automatic logic [31:0] do_bext(input logic [31:0] src, input logic [31:0] mask);
    logic [31:0] r;
    logic [5:0]  j;
    r = '0;
    j = '0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        r[j[4:0]] = src[i];
        j = j + 6'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] do_bdep(input logic [31:0] src, input logic [31:0] mask);
    logic [31:0] r;
    logic [5:0]  j;
    r = '0;
    j = '0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        r[i] = src[j[4:0]];
        j = j + 6'd1;
      end
    end
    return r;
  endfunction

  logic [31:0] stage [LAT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= bdep ? do_bdep(rs1, rs2) : do_bext(rs1, rs2);
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign rd = stage[LAT-1];

endmodule

// File: rtl/bextdep_arbiter.sv
// Round-robin share of one smartbextdep between two requesters; issue to respN_valid is LAT+1 cycles.
// Credit-gated per requester (no grant once its FIFO could fill); BEXTDEP_ARB_PERF_EN adds perf counters.
module bextdep_arbiter
  import bextdep_arb_pkg::*;
#(
  parameter int LAT       = LAT_DEFAULT,
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_bdep,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_bdep,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_rd,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_rd
`ifdef BEXTDEP_ARB_PERF_EN
  ,
  output logic [31:0] perf_issue0,
  output logic [31:0] perf_issue1,
  output logic [31:0] perf_conflict
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [NUM_REQ-1:0] req_valid, elig, cand, grant, pop, push, fifo_empty;
  logic [CW-1:0]      credit [NUM_REQ];
  logic               last_grant;
  logic               op_bdep;
  logic [31:0]        op_rs1, op_rs2, unit_rd;
  tag_t               tag_pipe [LAT];
  tag_t               exit_tag;

  assign req_valid = {req1_valid, req0_valid};

  always_comb begin
    for (int n = 0; n < NUM_REQ; n++) elig[n] = (credit[n] < CW'(BUF_DEPTH));
    cand  = req_valid & elig;
    grant = '0;
    if (reset) begin
      grant = '0;
    end else if (cand == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = cand;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign op_bdep = grant[1] ? req1_bdep : req0_bdep;
  assign op_rs1  = grant[1] ? req1_rs1  : req0_rs1;
  assign op_rs2  = grant[1] ? req1_rs2  : req0_rs2;

  smartbextdep #(.LAT(LAT)) u_unit (
    .clock (clock),
    .reset (reset),
    .bdep  (op_bdep),
    .rs1   (op_rs1),
    .rs2   (op_rs2),
    .rd    (unit_rd)
  );

  // Owner tags ride alongside the datapath so rd and owner exit together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
      for (int n = 0; n < NUM_REQ; n++) credit[n] <= '0;
      last_grant <= 1'b1;
    end else begin
      tag_pipe[0] <= '{vld: |grant, owner: grant[1]};
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      for (int n = 0; n < NUM_REQ; n++) credit[n] <= credit[n] + CW'(grant[n]) - CW'(pop[n]);
      if (|grant) last_grant <= grant[1];
    end
  end

  assign exit_tag = tag_pipe[LAT-1];
  assign push[0]  = exit_tag.vld && (exit_tag.owner == 1'b0);
  assign push[1]  = exit_tag.vld && (exit_tag.owner == 1'b1);

  assign resp0_valid = ~fifo_empty[0];
  assign resp1_valid = ~fifo_empty[1];
  assign pop[0]      = resp0_valid & resp0_ready;
  assign pop[1]      = resp1_valid & resp1_ready;

  bextdep_arb_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_fifo0 (
    .clock    (clock),
    .reset    (reset),
    .push     (push[0]),
    .push_dat (unit_rd),
    .pop      (pop[0]),
    .pop_dat  (resp0_rd),
    .empty    (fifo_empty[0])
  );

  bextdep_arb_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_fifo1 (
    .clock    (clock),
    .reset    (reset),
    .push     (push[1]),
    .push_dat (unit_rd),
    .pop      (pop[1]),
    .pop_dat  (resp1_rd),
    .empty    (fifo_empty[1])
  );

`ifdef BEXTDEP_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issue0   <= '0;
      perf_issue1   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_issue0   <= perf_issue0 + 32'(grant[0]);
      perf_issue1   <= perf_issue1 + 32'(grant[1]);
      perf_conflict <= perf_conflict + 32'(&req_valid);
    end
  end
`endif

endmodule

// File: tb/tb_bextdep_arbiter.sv
// Directed self-checking bench for bextdep_arbiter (LAT=2, BUF_DEPTH=4).
module tb_bextdep_arbiter;

  localparam int LAT = 2;
  localparam int BD  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_bdep;
  logic [31:0] req0_rs1, req0_rs2;
  logic        req1_valid, req1_ready, req1_bdep;
  logic [31:0] req1_rs1, req1_rs2;
  logic        resp0_valid, resp0_ready;
  logic [31:0] resp0_rd;
  logic        resp1_valid, resp1_ready;
  logic [31:0] resp1_rd;
`ifdef BEXTDEP_ARB_PERF_EN
  logic [31:0] perf_issue0, perf_issue1, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          glog[$];

  always #5 clock = ~clock;

  bextdep_arbiter #(.LAT(LAT), .BUF_DEPTH(BD)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_bdep   (req0_bdep),
    .req0_rs1    (req0_rs1),
    .req0_rs2    (req0_rs2),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_bdep   (req1_bdep),
    .req1_rs1    (req1_rs1),
    .req1_rs2    (req1_rs2),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_rd    (resp0_rd),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_rd    (resp1_rd)
`ifdef BEXTDEP_ARB_PERF_EN
    ,
    .perf_issue0   (perf_issue0),
    .perf_issue1   (perf_issue1),
    .perf_conflict (perf_conflict)
`endif
  );

  // Passive recorder of grants and consumed results, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (req0_valid && req0_ready) glog.push_back(0);
      if (req1_valid && req1_ready) glog.push_back(1);
      if (resp0_valid && resp0_ready) q0.push_back(resp0_rd);
      if (resp1_valid && resp1_ready) q1.push_back(resp1_rd);
    end
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_bdep = 0; req0_rs1 = '0; req0_rs2 = '0;
    req1_valid = 0; req1_bdep = 0; req1_rs1 = '0; req1_rs2 = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    q0.delete(); q1.delete(); glog.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    resp0_ready = 1; resp1_ready = 1;
    @(posedge clock); #1;
    req0_valid = 1; req1_valid = 1;
    @(posedge clock); #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_req0_ready got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_req1_ready got %b exp 0", req1_ready); end
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL rst_resp0_valid got %b exp 0", resp0_valid); end
    checks++; if (resp1_valid !== 1'b0) begin errors++; $display("FAIL rst_resp1_valid got %b exp 0", resp1_valid); end
    checks++; if (resp0_rd !== 32'h0) begin errors++; $display("FAIL rst_resp0_rd got %h exp 0", resp0_rd); end
    checks++; if (resp1_rd !== 32'h0) begin errors++; $display("FAIL rst_resp1_rd got %h exp 0", resp1_rd); end
    idle_inputs();
    #1 reset = 0;
  endtask

  task automatic test_single_bext();
    do_reset();
    resp0_ready = 0; resp1_ready = 1;
    @(posedge clock); #1;
    req0_valid = 1; req0_bdep = 0; req0_rs1 = 32'h12345678; req0_rs2 = 32'h0000FF00;
    @(negedge clock);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bext_ready got %b exp 1", req0_ready); end
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clock); #1;
      if (c == 1) req0_valid = 0;
      @(negedge clock);
      checks++;
      if (resp0_valid !== (c == LAT + 1)) begin
        errors++; $display("FAIL bext_latency cycle %0d got valid %b exp %b", c, resp0_valid, (c == LAT + 1));
      end
    end
    checks++; if (resp0_rd !== 32'h00000056) begin errors++; $display("FAIL bext_rd got %h exp 00000056", resp0_rd); end
    checks++; if (resp1_valid !== 1'b0) begin errors++; $display("FAIL bext_resp1_quiet got %b exp 0", resp1_valid); end
    @(posedge clock); #1 resp0_ready = 1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL bext_pop got valid %b exp 0", resp0_valid); end
  endtask

  task automatic test_single_bdep();
    do_reset();
    resp0_ready = 1; resp1_ready = 0;
    @(posedge clock); #1;
    req1_valid = 1; req1_bdep = 1; req1_rs1 = 32'h000000A5; req1_rs2 = 32'h0F0F0000;
    @(negedge clock);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bdep_ready got %b exp 1", req1_ready); end
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clock); #1;
      if (c == 1) req1_valid = 0;
      @(negedge clock);
      checks++;
      if (resp1_valid !== (c == LAT + 1)) begin
        errors++; $display("FAIL bdep_latency cycle %0d got valid %b exp %b", c, resp1_valid, (c == LAT + 1));
      end
    end
    checks++; if (resp1_rd !== 32'h0A050000) begin errors++; $display("FAIL bdep_rd got %h exp 0a050000", resp1_rd); end
    @(posedge clock); #1 resp1_ready = 1;
    @(posedge clock); #1;
  endtask

  // Requester 0: bext of k<<8 under mask 0xFF00 -> k. Requester 1: bdep of k into 0x00FF0000 -> k<<16.
  task automatic test_alternate();
    logic [31:0] k0, k1;
    do_reset();
    resp0_ready = 1; resp1_ready = 1;
    k0 = 1; k1 = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      req0_valid = 1; req0_bdep = 0; req0_rs1 = k0 << 8; req0_rs2 = 32'h0000FF00;
      req1_valid = 1; req1_bdep = 1; req1_rs1 = k1;      req1_rs2 = 32'h00FF0000;
      @(negedge clock);
      if (req0_ready) k0 = k0 + 1;
      if (req1_ready) k1 = k1 + 1;
    end
    @(posedge clock); #1 idle_inputs();
    repeat (LAT + 4) @(negedge clock);
    checks++; if (glog.size() != 20) begin errors++; $display("FAIL alt_grant_count got %0d exp 20", glog.size()); end
    for (int i = 0; i < glog.size() && i < 20; i++) begin
      checks++; if (glog[i] != i % 2) begin errors++; $display("FAIL alt_grant_order idx %0d got %0d exp %0d", i, glog[i], i % 2); end
    end
    checks++; if (q0.size() != 10) begin errors++; $display("FAIL alt_resp0_count got %0d exp 10", q0.size()); end
    checks++; if (q1.size() != 10) begin errors++; $display("FAIL alt_resp1_count got %0d exp 10", q1.size()); end
    for (int i = 0; i < q0.size() && i < 10; i++) begin
      checks++; if (q0[i] !== 32'(i + 1)) begin errors++; $display("FAIL alt_resp0 idx %0d got %h exp %h", i, q0[i], 32'(i + 1)); end
    end
    for (int i = 0; i < q1.size() && i < 10; i++) begin
      checks++; if (q1[i] !== (32'(i + 1) << 16)) begin errors++; $display("FAIL alt_resp1 idx %0d got %h exp %h", i, q1[i], 32'(i + 1) << 16); end
    end
`ifdef BEXTDEP_ARB_PERF_EN
    checks++; if (perf_issue0 !== 32'd10) begin errors++; $display("FAIL perf_issue0 got %0d exp 10", perf_issue0); end
    checks++; if (perf_issue1 !== 32'd10) begin errors++; $display("FAIL perf_issue1 got %0d exp 10", perf_issue1); end
    checks++; if (perf_conflict !== 32'd20) begin errors++; $display("FAIL perf_conflict got %0d exp 20", perf_conflict); end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] k0, k1;
    int acc0, late1, both;
    do_reset();
    resp0_ready = 0; resp1_ready = 1;
    k0 = 1; k1 = 1; acc0 = 0; late1 = 0; both = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clock); #1;
      req0_valid = 1; req0_bdep = 0; req0_rs1 = k0 << 8; req0_rs2 = 32'h0000FF00;
      req1_valid = 1; req1_bdep = 1; req1_rs1 = k1;      req1_rs2 = 32'h00FF0000;
      @(negedge clock);
      if (req0_ready && req1_ready) both++;
      if (req0_ready) begin acc0++; k0 = k0 + 1; end
      if (req1_ready) begin k1 = k1 + 1; if (c >= 14) late1++; end
    end
    checks++; if (acc0 != BD) begin errors++; $display("FAIL bp_req0_issues got %0d exp %0d", acc0, BD); end
    checks++; if (late1 != 10) begin errors++; $display("FAIL bp_req1_stream got %0d exp 10", late1); end
    checks++; if (both != 0) begin errors++; $display("FAIL bp_dual_ready got %0d exp 0", both); end
    checks++; if (resp0_valid !== 1'b1) begin errors++; $display("FAIL bp_resp0_held got %b exp 1", resp0_valid); end
    @(posedge clock); #1 idle_inputs();
    repeat (LAT + 2) @(posedge clock);
    #1 resp0_ready = 1;
    repeat (8) @(negedge clock);
    checks++; if (q0.size() != BD) begin errors++; $display("FAIL bp_drain_count got %0d exp %0d", q0.size(), BD); end
    for (int i = 0; i < q0.size() && i < BD; i++) begin
      checks++; if (q0[i] !== 32'(i + 1)) begin errors++; $display("FAIL bp_drain idx %0d got %h exp %h", i, q0[i], 32'(i + 1)); end
    end
    @(posedge clock); #1 req0_valid = 1;
    @(negedge clock);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_credit_return got %b exp 1", req0_ready); end
    @(posedge clock); #1 idle_inputs();
    repeat (LAT + 3) @(posedge clock);
  endtask

  task automatic test_reset_midop();
    int spurious;
    do_reset();
    resp0_ready = 0; resp1_ready = 0;
    @(posedge clock); #1;
    req0_valid = 1; req0_bdep = 0; req0_rs1 = 32'h12345678; req0_rs2 = 32'h0000FF00;
    @(negedge clock);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_issue got %b exp 1", req0_ready); end
    @(posedge clock); #1;
    req0_valid = 0;
    @(negedge clock);
    reset = 1;
    #1;
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL midrst_req0_ready got %b exp 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_req1_ready got %b exp 0", req1_ready); end
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL midrst_resp0_valid got %b exp 0", resp0_valid); end
    checks++; if (resp0_rd !== 32'h0) begin errors++; $display("FAIL midrst_resp0_rd got %h exp 0", resp0_rd); end
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    spurious = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (resp0_valid || resp1_valid) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL midrst_ghost_result got %0d exp 0", spurious); end
    @(posedge clock); #1;
    req0_valid = 1; req0_bdep = 0; req0_rs1 = 32'h000000F0; req0_rs2 = 32'h000000FF;
    @(posedge clock); #1 req0_valid = 0;
    repeat (LAT) @(posedge clock);
    @(negedge clock);
    checks++; if (resp0_valid !== 1'b1) begin errors++; $display("FAIL midrst_new_valid got %b exp 1", resp0_valid); end
    checks++; if (resp0_rd !== 32'h000000F0) begin errors++; $display("FAIL midrst_new_rd got %h exp 000000f0", resp0_rd); end
  endtask

  initial begin
    test_reset();
    test_single_bext();
    test_single_bdep();
    test_alternate();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
